// File: rtl/vga_pkg.sv
// Shared timing constants and geometry for the 640x480@60 scan path.
package vga_pkg;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_FP     = 16;
    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BP     = 48;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_FP     = 10;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BP     = 33;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int unsigned COLS     = 80;
    localparam int unsigned ROWS     = 30;
    localparam int unsigned GLYPH_W  = 8;
    localparam int unsigned GLYPH_H  = 16;

    localparam int unsigned GFX_COLS = 160;
    localparam int unsigned GFX_ROWS = 120;
    localparam int unsigned GFX_REP  = 4;

    typedef logic [9:0]  cnt_t;
    typedef logic [15:0] addr_t;

    typedef struct packed {
        logic hs_n;
        logic vs_n;
        logic de;
    } sync_t;

endpackage

// File: rtl/vga_sync_delay.sv
// Enabled shift register used to align sync/enable with VRAM read data.
module vga_sync_delay #(
    parameter int unsigned DEPTH   = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] sr_q;
    logic [DEPTH-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (en) begin
            sr_d    = sr_q << 1;
            sr_d[0] = d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sr_q <= {DEPTH{RST_VAL}};
        else        sr_q <= sr_d;
    end

    assign q = sr_q[DEPTH-1];

endmodule

// File: rtl/vga_scan_gen.sv
// VGA timing plus text/graphics VRAM address generation; row bases are
// accumulated per line so no multipliers are needed.
module vga_scan_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int unsigned H_FP     = vga_pkg::H_FP,
    parameter int unsigned H_SYNC   = vga_pkg::H_SYNC,
    parameter int unsigned H_BP     = vga_pkg::H_BP,
    parameter int unsigned V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int unsigned V_FP     = vga_pkg::V_FP,
    parameter int unsigned V_SYNC   = vga_pkg::V_SYNC,
    parameter int unsigned V_BP     = vga_pkg::V_BP,
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned PIPE_DLY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        pix_tick,
    output logic        hsync,
    output logic        vsync,
    output logic        video_de,
    output logic        frame_start,
    output logic [15:0] fontmode_addr,
    output logic [15:0] graphmode_addr,
    output logic [3:0]  glyph_row,
    output logic [2:0]  glyph_col
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam cnt_t H_LAST   = cnt_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam cnt_t V_LAST   = cnt_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam cnt_t H_ACT    = cnt_t'(H_ACTIVE);
    localparam cnt_t V_ACT    = cnt_t'(V_ACTIVE);
    localparam cnt_t HS_FIRST = cnt_t'(H_ACTIVE + H_FP);
    localparam cnt_t HS_LAST  = cnt_t'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam cnt_t VS_FIRST = cnt_t'(V_ACTIVE + V_FP);
    localparam cnt_t VS_LAST  = cnt_t'(V_ACTIVE + V_FP + V_SYNC - 1);

    localparam int unsigned GW_SH = $clog2(GLYPH_W);
    localparam int unsigned GH_SH = $clog2(GLYPH_H);
    localparam int unsigned GR_SH = $clog2(GFX_REP);
    localparam addr_t FONT_STEP = addr_t'(COLS);
    localparam addr_t GFX_STEP  = addr_t'(GFX_COLS);

    logic [DIV_W-1:0] div_q, div_d;
    logic             pix_tick_q, pix_tick_d;
    logic             frame_start_q, frame_start_d;
    cnt_t             h_cnt_q, h_cnt_d;
    cnt_t             v_cnt_q, v_cnt_d;
    addr_t            font_base_q, font_base_d;
    addr_t            graph_base_q, graph_base_d;
    addr_t            font_addr_q, font_addr_d;
    addr_t            graph_addr_q, graph_addr_d;
    logic [3:0]       glyph_row_q, glyph_row_d;
    logic [2:0]       glyph_col_q, glyph_col_d;
    logic             active;
    sync_t            raw;

    always_comb begin
        div_d         = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        pix_tick_d    = (div_q == DIV_LAST);
        frame_start_d = 1'b0;
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        font_base_d   = font_base_q;
        graph_base_d  = graph_base_q;
        font_addr_d   = font_addr_q;
        graph_addr_d  = graph_addr_q;
        glyph_row_d   = glyph_row_q;
        glyph_col_d   = glyph_col_q;

        active   = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        raw.hs_n = !((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST));
        raw.vs_n = !((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST));
        raw.de   = active;

        if (pix_tick_q) begin
            font_addr_d  = active ? font_base_q + addr_t'(h_cnt_q >> GW_SH) : '0;
            graph_addr_d = active ? graph_base_q + addr_t'(h_cnt_q >> GR_SH) : '0;
            glyph_row_d  = active ? v_cnt_q[GH_SH-1:0] : '0;
            glyph_col_d  = active ? h_cnt_q[GW_SH-1:0] : '0;

            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                if (v_cnt_q == V_LAST) begin
                    v_cnt_d       = '0;
                    font_base_d   = '0;
                    graph_base_d  = '0;
                    frame_start_d = 1'b1;
                end else begin
                    v_cnt_d = v_cnt_q + 1'b1;
                    // Bases track the line being entered, so step on its low bits.
                    if (v_cnt_d[GH_SH-1:0] == '0) font_base_d  = font_base_q + FONT_STEP;
                    if (v_cnt_d[GR_SH-1:0] == '0) graph_base_d = graph_base_q + GFX_STEP;
                end
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q         <= '0;
            pix_tick_q    <= 1'b0;
            frame_start_q <= 1'b0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            font_base_q   <= '0;
            graph_base_q  <= '0;
            font_addr_q   <= '0;
            graph_addr_q  <= '0;
            glyph_row_q   <= '0;
            glyph_col_q   <= '0;
        end else begin
            div_q         <= div_d;
            pix_tick_q    <= pix_tick_d;
            frame_start_q <= frame_start_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            font_base_q   <= font_base_d;
            graph_base_q  <= graph_base_d;
            font_addr_q   <= font_addr_d;
            graph_addr_q  <= graph_addr_d;
            glyph_row_q   <= glyph_row_d;
            glyph_col_q   <= glyph_col_d;
        end
    end

    vga_sync_delay #(.DEPTH(PIPE_DLY), .RST_VAL(1'b1)) u_hs_dly (
        .clk(clk), .rst_n(rst_n), .en(pix_tick_q), .d(raw.hs_n), .q(hsync)
    );

    vga_sync_delay #(.DEPTH(PIPE_DLY), .RST_VAL(1'b1)) u_vs_dly (
        .clk(clk), .rst_n(rst_n), .en(pix_tick_q), .d(raw.vs_n), .q(vsync)
    );

    vga_sync_delay #(.DEPTH(PIPE_DLY), .RST_VAL(1'b0)) u_de_dly (
        .clk(clk), .rst_n(rst_n), .en(pix_tick_q), .d(raw.de), .q(video_de)
    );

    assign pix_tick       = pix_tick_q;
    assign frame_start    = frame_start_q;
    assign fontmode_addr  = font_addr_q;
    assign graphmode_addr = graph_addr_q;
    assign glyph_row      = glyph_row_q;
    assign glyph_col      = glyph_col_q;

endmodule
